if_id_skid_reg: RTL and testbench

Parametrised IF/ID pipeline register for the RISC-V pipeline with a valid/ready handshake, a one-entry skid buffer, and a branch/jump flush. It captures PC, PC+4 and the fetched instruction from IF and presents them to ID. It sustains one instruction per cycle. When ID stalls, it holds in-flight data without a combinational path from `out_ready` to `in_ready`.

---
 rtl/if_id_skid_reg_if.sv | 31 +++
 rtl/if_id_skid_reg.sv | 171 +++++++++++++++++
 tb/tb_if_id_skid_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_reg_if.sv
// IF/ID handshake bundle: upstream fetch fields with valid/ready, downstream
// registered fields with valid/ready.
interface if_id_skid_reg_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PC_incremented_by_4;
    logic [XLEN-1:0] Instruction;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] PC_reg_out;
    logic [XLEN-1:0] PC_incremented_by_4_reg_out;
    logic [XLEN-1:0] Instruction_reg_out;

    // master: the environment driving IF and consuming in ID
    modport master (
        output in_valid, PC, PC_incremented_by_4, Instruction, out_ready,
        input  in_ready, out_valid, PC_reg_out, PC_incremented_by_4_reg_out,
               Instruction_reg_out
    );

    // slave: the pipeline register itself
    modport slave (
        input  in_valid, PC, PC_incremented_by_4, Instruction, out_ready,
        output in_ready, out_valid, PC_reg_out, PC_incremented_by_4_reg_out,
               Instruction_reg_out
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer and branch flush.
// Optional stall/flush performance counters are enabled with IF_ID_PERF_CNT_EN.
//
// state   | meaning
// --------+------------------------------------------
// S_EMPTY | main invalid, outputs show NOP / zero PCs
// S_FULL  | main valid, skid empty
// S_SKID  | main and skid both valid, in_ready low
module if_id_skid_reg #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int              CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    if_id_skid_reg_if.slave  bus
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_SKID  = 2'd2;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_IN    = 2'd1;
    localparam logic [1:0] SEL_SKID  = 2'd2;
    localparam logic [1:0] SEL_CLEAR = 2'd3;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_main_pc4;
    logic [XLEN-1:0] r_main_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_pc4;
    logic [XLEN-1:0] r_skid_instr;

    logic [1:0] w_state_nxt;
    logic [1:0] w_main_sel;
    logic       w_skid_load;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_accept;
    logic       w_take;

    // in_ready comes from registered state only, so out_ready never reaches it
    assign w_in_ready  = (r_state != S_SKID);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_take      = w_out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_sel  = SEL_HOLD;
        w_skid_load = 1'b0;
        if (FLUSH) begin
            w_state_nxt = S_EMPTY;
            w_main_sel  = SEL_CLEAR;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = S_FULL;
                        w_main_sel  = SEL_IN;
                    end
                end
                S_FULL: begin
                    if (w_take && w_accept) begin
                        w_main_sel = SEL_IN;
                    end else if (w_take) begin
                        w_state_nxt = S_EMPTY;
                        w_main_sel  = SEL_CLEAR;
                    end else if (w_accept) begin
                        w_state_nxt = S_SKID;
                        w_skid_load = 1'b1;
                    end
                end
                S_SKID: begin
                    if (w_take) begin
                        w_state_nxt = S_FULL;
                        w_main_sel  = SEL_SKID;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_sel  = SEL_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_EMPTY;
            r_main_pc    <= '0;
            r_main_pc4   <= '0;
            r_main_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            case (w_main_sel)
                SEL_IN: begin
                    r_main_pc    <= bus.PC;
                    r_main_pc4   <= bus.PC_incremented_by_4;
                    r_main_instr <= bus.Instruction;
                end
                SEL_SKID: begin
                    r_main_pc    <= r_skid_pc;
                    r_main_pc4   <= r_skid_pc4;
                    r_main_instr <= r_skid_instr;
                end
                SEL_CLEAR: begin
                    r_main_pc    <= '0;
                    r_main_pc4   <= '0;
                    r_main_instr <= NOP_INSTR;
                end
                default: begin
                    r_main_pc    <= r_main_pc;
                    r_main_pc4   <= r_main_pc4;
                    r_main_instr <= r_main_instr;
                end
            endcase
        end
    end

    // skid contents are only meaningful in S_SKID, so no reset or clear needed
    always_ff @(posedge CLK) begin
        if (w_skid_load) begin
            r_skid_pc    <= bus.PC;
            r_skid_pc4   <= bus.PC_incremented_by_4;
            r_skid_instr <= bus.Instruction;
        end
    end

    assign bus.in_ready                    = w_in_ready;
    assign bus.out_valid                   = w_out_valid;
    assign bus.PC_reg_out                  = r_main_pc;
    assign bus.PC_incremented_by_4_reg_out = r_main_pc4;
    assign bus.Instruction_reg_out         = r_main_instr;

`ifdef IF_ID_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_out_valid && !bus.out_ready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (FLUSH && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign flush_count  = r_flush_cnt;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed plus pseudo-random bench for if_id_skid_reg with a FIFO scoreboard.
module tb_if_id_skid_reg;
    localparam int          XLEN = 32;
    localparam int          CNT_W = 4;
    localparam int          CMAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic CLK = 1'b0;
    logic RESET;
    logic FLUSH;

    if_id_skid_reg_if #(.XLEN(XLEN)) bus ();

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
`endif

    if_id_skid_reg #(
        .XLEN(XLEN),
        .NOP_INSTR(NOP),
        .CNT_W(CNT_W)
    ) u_dut (
        .CLK(CLK),
        .RESET(RESET),
        .FLUSH(FLUSH),
        .bus(bus)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    entry_t q[$];
    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int n_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("pc_out", bus.PC_reg_out, q[0].pc);
            chk("pc4_out", bus.PC_incremented_by_4_reg_out, q[0].pc4);
            chk("instr_out", bus.Instruction_reg_out, q[0].instr);
        end else begin
            chk("pc_out_empty", bus.PC_reg_out, 32'd0);
            chk("pc4_out_empty", bus.PC_incremented_by_4_reg_out, 32'd0);
            chk("instr_out_empty", bus.Instruction_reg_out, NOP);
        end
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_cycles", {28'd0, stall_cycles}, exp_stall);
        chk("flush_count", {28'd0, flush_count}, exp_flush);
`endif
    endtask

    // check current outputs, drive one cycle of inputs, advance the model
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy);
        logic acc;
        logic tk;
        check_state();
        RESET                   = rst;
        FLUSH                   = fl;
        bus.in_valid            = iv;
        bus.PC                  = pc;
        bus.PC_incremented_by_4 = pc + 32'd4;
        bus.Instruction         = ins;
        bus.out_ready           = ordy;
        acc = iv && (q.size() < 2);
        tk  = ordy && (q.size() > 0);
        if (rst) begin
            q.delete();
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (q.size() > 0 && !ordy && exp_stall < CMAX) exp_stall++;
            if (fl && exp_flush < CMAX) exp_flush++;
            if (tk) begin
                void'(q.pop_front());
                n_out++;
            end
            if (fl) q.delete();
            else if (acc) q.push_back('{pc, pc + 32'd4, ins});
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] pcv;
        RESET = 1'b1;
        FLUSH = 1'b0;
        bus.in_valid = 1'b0;
        bus.PC = '0;
        bus.PC_incremented_by_4 = '0;
        bus.Instruction = '0;
        bus.out_ready = 1'b0;
        @(posedge CLK);
        #1;

        // reset then idle
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("reset_instr_nop", bus.Instruction_reg_out, 32'h00000013);

        // streaming at full rate
        step(0, 0, 1, 32'h0, 32'hAAAA_0001, 1);
        step(0, 0, 1, 32'h4, 32'hBBBB_0002, 1);
        step(0, 0, 1, 32'h8, 32'hCCCC_0003, 1);
        chk("stream_pc4_c", bus.PC_incremented_by_4_reg_out, 32'hC);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("stream_count", n_out, 3);

        // stall fills the skid; third offer must be refused
        step(0, 0, 1, 32'h10, 32'h1111_0010, 0);
        step(0, 0, 1, 32'h14, 32'h1111_0014, 0);
        chk("stall_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_hold_pc", bus.PC_reg_out, 32'h10);
        step(0, 0, 1, 32'h18, 32'h1111_0018, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("release_pc", bus.PC_reg_out, 32'h14);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // flush in SKID with a same-cycle input
        step(0, 0, 1, 32'h30, 32'h2222_0030, 0);
        step(0, 0, 1, 32'h34, 32'h2222_0034, 0);
        step(0, 1, 1, 32'h20, 32'h2222_0020, 0);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_instr_nop", bus.Instruction_reg_out, NOP);
        step(0, 0, 0, 0, 0, 1);

        // flush together with take
        step(0, 0, 1, 32'h40, 32'h3333_0040, 0);
        step(0, 1, 1, 32'h44, 32'h3333_0044, 1);
        step(0, 0, 0, 0, 0, 1);

        // reset in SKID
        step(0, 0, 1, 32'h50, 32'h4444_0050, 0);
        step(0, 0, 1, 32'h54, 32'h4444_0054, 0);
        step(1, 1, 1, 32'h58, 32'h4444_0058, 0);
        chk("reset_mid_stall_pc", bus.PC_reg_out, 32'd0);
        step(0, 0, 0, 0, 0, 0);

        // pseudo-random traffic
        pcv = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), pcv,
                 $urandom, ($urandom_range(0, 3) != 0));
            pcv = pcv + 32'd4;
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

`ifdef IF_ID_PERF_CNT_EN
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h60, 32'h5555_0060, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
        chk("stall_saturated", {28'd0, stall_cycles}, 32'd15);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("flush_count_3", {28'd0, flush_count}, 32'd3);
`endif
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
